// File: rtl/stepper_scan_pkg.sv
// Shared types and helpers for the stepper scan-head controller.
package stepper_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FWD,
        ST_REV
    } scan_state_e;

    // Ticks between steps at a position: longer within ramp_len of either end.
    function automatic int ramp_period(int pos, int scan_len, int ramp_len, int ramp_shift);
        int d;
        d = (pos < scan_len - pos) ? pos : scan_len - pos;
        return (d < ramp_len) ? 1 + ((ramp_len - d) >> ramp_shift) : 1;
    endfunction

    function automatic bit in_window(int pos, int win_start, int win_len);
        return (pos >= win_start) && (pos < win_start + win_len);
    endfunction

    function automatic bit scan_params_ok(int clk_div, int pos_w, int scan_len, int win_start,
                                          int win_len, int ramp_len, int ramp_shift);
        return (clk_div >= 2) && (pos_w >= 1) && (pos_w < 31) && (scan_len < (1 << pos_w)) &&
               (win_start >= 0) && (win_len >= 2) && (win_start + win_len <= scan_len) &&
               (ramp_len >= 0) && (2 * ramp_len <= scan_len) && (ramp_shift >= 0);
    endfunction

endpackage

// File: rtl/clk_tick_gen.sv
// Free-running divider: tick is high for one clk out of every CLK_DIV.
module clk_tick_gen #(
    parameter int CLK_DIV = 20
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] count;

    assign tick = (count == CNT_W'(CLK_DIV - 1));

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset)     count <= '0;
        else if (tick) count <= '0;
        else           count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/stepper_scan_ctrl.sv
// Scan-head controller: ramped home/far-end sweeps with an LED pixel window,
// plus one-shot, abort and unidirectional-imaging modes.
module stepper_scan_ctrl
    import stepper_scan_pkg::*;
#(
    parameter int CLK_DIV    = 20,
    parameter int POS_W      = 7,
    parameter int SCAN_LEN   = 126,
    parameter int WIN_START  = 15,
    parameter int WIN_LEN    = 100,
    parameter int RAMP_LEN   = 14,
    parameter int RAMP_SHIFT = 2,
    parameter int UNIDIR     = 0,
    localparam int PIX_W     = $clog2(WIN_LEN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             oneshot,
    input  logic             abort,
    output logic             step,
    output logic             dir,
    output logic             pixel_clock,
    output logic             nOE,
    output logic [PIX_W-1:0] pixel_idx,
    output logic [POS_W-1:0] pos,
    output logic             busy,
    output logic             line_done
);

    localparam int WAIT_W = $clog2(RAMP_LEN + 2);

    if (!scan_params_ok(CLK_DIV, POS_W, SCAN_LEN, WIN_START, WIN_LEN, RAMP_LEN, RAMP_SHIFT))
    begin : g_bad_params
        $error("stepper_scan_ctrl: illegal parameter combination");
    end

    scan_state_e       state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              armed;
    logic              abort_latched;
    logic              tick;
    logic              step_due;
    logic              at_dwell;
    logic [POS_W-1:0]  pos_step;

    clk_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // LEDs are lit only inside the window while moving in an imaging direction.
    function automatic logic led_off(scan_state_e st, logic [POS_W-1:0] p);
        return !(in_window(int'(p), WIN_START, WIN_LEN) &&
                 (st == ST_FWD || (st == ST_REV && UNIDIR == 0)));
    endfunction

    assign pos_step = (state == ST_REV) ? pos - POS_W'(1) : pos + POS_W'(1);
    assign step_due = (int'(wait_cnt) + 1) >= ramp_period(int'(pos), SCAN_LEN, RAMP_LEN, RAMP_SHIFT);
    assign at_dwell = (state == ST_FWD) ? (pos == POS_W'(SCAN_LEN) || abort_latched)
                                        : (pos == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            pos           <= '0;
            wait_cnt      <= '0;
            armed         <= 1'b1;
            abort_latched <= 1'b0;
            step          <= 1'b0;
            dir           <= 1'b0;
            pixel_clock   <= 1'b0;
            nOE           <= 1'b1;
            pixel_idx     <= '0;
            busy          <= 1'b0;
            line_done     <= 1'b0;
        end else begin
            step        <= 1'b0;
            pixel_clock <= 1'b0;
            line_done   <= 1'b0;
            if (!run) armed <= 1'b1;
            if (abort && state != ST_IDLE) abort_latched <= 1'b1;

            if (tick) begin
                if (state == ST_IDLE) begin
                    if (run && armed) begin
                        state    <= ST_FWD;
                        busy     <= 1'b1;
                        wait_cnt <= '0;
                        nOE      <= led_off(ST_FWD, pos);
                        if (oneshot) armed <= 1'b0;
                    end
                end else if (at_dwell) begin
                    line_done <= 1'b1;
                    wait_cnt  <= '0;
                    if (state == ST_FWD) begin
                        state <= ST_REV;
                        dir   <= 1'b1;
                        nOE   <= led_off(ST_REV, pos);
                    end else if (run && !oneshot && !abort_latched) begin
                        state <= ST_FWD;
                        dir   <= 1'b0;
                        nOE   <= led_off(ST_FWD, pos);
                    end else begin
                        state         <= ST_IDLE;
                        dir           <= 1'b0;
                        busy          <= 1'b0;
                        nOE           <= 1'b1;
                        abort_latched <= 1'b0;
                    end
                end else if (step_due) begin
                    step     <= 1'b1;
                    pos      <= pos_step;
                    wait_cnt <= '0;
                    nOE      <= led_off(state, pos_step);
                    if (!led_off(state, pos_step)) begin
                        pixel_clock <= 1'b1;
                        pixel_idx   <= PIX_W'(pos_step - POS_W'(WIN_START));
                    end
                end else begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_stepper_scan_ctrl.sv
// Bench for stepper_scan_ctrl: a bidirectional and a unidirectional instance
// share stimulus; expected tick traces are expanded from whole-sweep rules.
module tb_stepper_scan_ctrl;

    localparam int CLK_DIV    = 4;
    localparam int POS_W      = 5;
    localparam int SCAN_LEN   = 20;
    localparam int WIN_START  = 5;
    localparam int WIN_LEN    = 10;
    localparam int RAMP_LEN   = 4;
    localparam int RAMP_SHIFT = 0;
    localparam int PIX_W      = $clog2(WIN_LEN);
    localparam int S_IDLE = 0, S_FWD = 1, S_REV = 2;

    logic clk = 1'b0;
    logic reset = 1'b1, run = 1'b0, oneshot = 1'b0, abort = 1'b0;

    logic step0, dir0, pix0, noe0, busy0, ld0;
    logic step1, dir1, pix1, noe1, busy1, ld1;
    logic [PIX_W-1:0] idx0, idx1;
    logic [POS_W-1:0] pos0, pos1;

    stepper_scan_ctrl #(
        .CLK_DIV(CLK_DIV), .POS_W(POS_W), .SCAN_LEN(SCAN_LEN), .WIN_START(WIN_START),
        .WIN_LEN(WIN_LEN), .RAMP_LEN(RAMP_LEN), .RAMP_SHIFT(RAMP_SHIFT), .UNIDIR(0)
    ) u_bidir (
        .clk(clk), .reset(reset), .run(run), .oneshot(oneshot), .abort(abort),
        .step(step0), .dir(dir0), .pixel_clock(pix0), .nOE(noe0), .pixel_idx(idx0),
        .pos(pos0), .busy(busy0), .line_done(ld0)
    );

    stepper_scan_ctrl #(
        .CLK_DIV(CLK_DIV), .POS_W(POS_W), .SCAN_LEN(SCAN_LEN), .WIN_START(WIN_START),
        .WIN_LEN(WIN_LEN), .RAMP_LEN(RAMP_LEN), .RAMP_SHIFT(RAMP_SHIFT), .UNIDIR(1)
    ) u_unidir (
        .clk(clk), .reset(reset), .run(run), .oneshot(oneshot), .abort(abort),
        .step(step1), .dir(dir1), .pixel_clock(pix1), .nOE(noe1), .pixel_idx(idx1),
        .pos(pos1), .busy(busy1), .line_done(ld1)
    );

    always #5 clk = ~clk;

    typedef enum {ACT_NONE, ACT_ABORT, ACT_RUN_LOW, ACT_RESET} act_e;

    typedef struct {
        logic       step, dir, busy, ld;
        logic [1:0] pix, noe;
        int         pos, idx0, idx1;
        act_e       act;
    } rec_t;

    rec_t q[$];
    int   m_idx [2];
    int   pix_fwd [2];
    int   pix_rev [2];
    int   vectors = 0;
    int   errors  = 0;
    int   tick_no = 0;

    function automatic int period(int p);
        int d;
        d = (p < SCAN_LEN - p) ? p : SCAN_LEN - p;
        return (d < RAMP_LEN) ? 1 + ((RAMP_LEN - d) >> RAMP_SHIFT) : 1;
    endfunction

    function automatic bit in_win(int p);
        return p >= WIN_START && p < WIN_START + WIN_LEN;
    endfunction

    // Append one expected tick; st is the controller state after the tick.
    task automatic push(logic s, logic ld, int p, int st, act_e act);
        rec_t r;
        r.step = s; r.ld = ld; r.pos = p; r.act = act;
        r.dir  = (st == S_REV);
        r.busy = (st != S_IDLE);
        for (int u = 0; u < 2; u++) begin
            logic lit;
            lit = in_win(p) && (st == S_FWD || (st == S_REV && u == 0));
            r.noe[u] = !lit;
            r.pix[u] = s && lit;
            if (r.pix[u]) m_idx[u] = p - WIN_START;
        end
        r.idx0 = m_idx[0];
        r.idx1 = m_idx[1];
        q.push_back(r);
    endtask

    // Expand one round trip: optional start tick, ramped forward sweep (cut
    // short by abort), dwell, ramped return, final dwell (continue or idle).
    task automatic plan_trip(bit from_idle, act_e act, int act_pos, bit cont);
        int p;
        p = 0;
        if (from_idle) push(1'b0, 1'b0, 0, S_FWD, ACT_NONE);
        while (p < SCAN_LEN) begin
            repeat (period(p) - 1) push(1'b0, 1'b0, p, S_FWD, ACT_NONE);
            p++;
            push(1'b1, 1'b0, p, S_FWD, (p == act_pos) ? act : ACT_NONE);
            if (act == ACT_ABORT && p == act_pos) break;
        end
        push(1'b0, 1'b1, p, S_REV, ACT_NONE);
        while (p > 0) begin
            repeat (period(p) - 1) push(1'b0, 1'b0, p, S_REV, ACT_NONE);
            p--;
            push(1'b1, 1'b0, p, S_REV, ACT_NONE);
        end
        push(1'b0, 1'b1, 0, cont ? S_FWD : S_IDLE, ACT_NONE);
    endtask

    task automatic plan_idle(int n);
        repeat (n) push(1'b0, 1'b0, 0, S_IDLE, ACT_NONE);
    endtask

    // Advance to #1 after the next tick edge; pulses must be low one clk after any tick.
    task automatic do_tick();
        @(posedge clk); #1;
        vectors++;
        if ({step0, pix0, ld0, step1, pix1, ld1} !== 6'b0) begin
            errors++;
            $display("FAIL pulse_width tick%0d: pulses=%b required 000000", tick_no,
                     {step0, pix0, ld0, step1, pix1, ld1});
        end
        repeat (CLK_DIV - 1) @(posedge clk);
        #1;
        tick_no++;
    endtask

    task automatic check_reset_values(string name);
        vectors++;
        if ({step0, dir0, pix0, noe0, busy0, ld0, step1, dir1, pix1, noe1, busy1, ld1} !== 12'b000100_000100
            || pos0 !== '0 || pos1 !== '0 || idx0 !== '0 || idx1 !== '0) begin
            errors++;
            $display("FAIL %s: step/dir/pix/nOE/busy/ld=%b%b%b%b%b%b,%b%b%b%b%b%b pos=%0d,%0d idx=%0d,%0d required 000100,000100 pos 0 idx 0",
                     name, step0, dir0, pix0, noe0, busy0, ld0, step1, dir1, pix1, noe1, busy1, ld1,
                     pos0, pos1, idx0, idx1);
        end
    endtask

    // Play the planned ticks, compare both instances, and apply per-tick actions.
    task automatic run_queue();
        while (q.size() > 0) begin
            rec_t r;
            r = q.pop_front();
            do_tick();
            abort = 1'b0;
            vectors += 2;
            if ({step0, dir0, busy0, ld0, pix0, noe0} !== {r.step, r.dir, r.busy, r.ld, r.pix[0], r.noe[0]}
                || pos0 !== POS_W'(r.pos) || idx0 !== PIX_W'(r.idx0)) begin
                errors++;
                $display("FAIL trace_bidir tick%0d: got step%b dir%b busy%b ld%b pix%b nOE%b pos%0d idx%0d, required step%b dir%b busy%b ld%b pix%b nOE%b pos%0d idx%0d",
                         tick_no, step0, dir0, busy0, ld0, pix0, noe0, pos0, idx0,
                         r.step, r.dir, r.busy, r.ld, r.pix[0], r.noe[0], r.pos, r.idx0);
            end
            if ({step1, dir1, busy1, ld1, pix1, noe1} !== {r.step, r.dir, r.busy, r.ld, r.pix[1], r.noe[1]}
                || pos1 !== POS_W'(r.pos) || idx1 !== PIX_W'(r.idx1)) begin
                errors++;
                $display("FAIL trace_unidir tick%0d: got step%b dir%b busy%b ld%b pix%b nOE%b pos%0d idx%0d, required step%b dir%b busy%b ld%b pix%b nOE%b pos%0d idx%0d",
                         tick_no, step1, dir1, busy1, ld1, pix1, noe1, pos1, idx1,
                         r.step, r.dir, r.busy, r.ld, r.pix[1], r.noe[1], r.pos, r.idx1);
            end
            if (pix0) begin if (r.dir) pix_rev[0]++; else pix_fwd[0]++; end
            if (pix1) begin if (r.dir) pix_rev[1]++; else pix_fwd[1]++; end
            case (r.act)
                ACT_ABORT:   abort = 1'b1;
                ACT_RUN_LOW: run = 1'b0;
                ACT_RESET: begin
                    q.delete();
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1 reset = 1'b1;
                    @(posedge clk); #1;
                    check_reset_values("reset_mid_sweep");
                    @(negedge clk) reset = 1'b0;
                    m_idx = '{0, 0};
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset_state");
        m_idx = '{0, 0};
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic test_ramp_round_trip();
        pix_fwd = '{0, 0};
        pix_rev = '{0, 0};
        run = 1'b1;
        plan_trip(1'b1, ACT_NONE, 0, 1'b1);
        run_queue();
        vectors++;
        if (pix_fwd[0] != WIN_LEN || pix_rev[0] != WIN_LEN || pix_fwd[1] != WIN_LEN || pix_rev[1] != 0) begin
            errors++;
            $display("FAIL pixel_counts: bidir fwd%0d rev%0d unidir fwd%0d rev%0d, required %0d %0d %0d 0",
                     pix_fwd[0], pix_rev[0], pix_fwd[1], pix_rev[1], WIN_LEN, WIN_LEN, WIN_LEN);
        end
    endtask

    // Continuous sweeps, then run drops mid-sweep and the trip completes.
    task automatic test_back_to_back();
        int n;
        n = $urandom_range(1, 2);
        repeat (n) plan_trip(1'b0, ACT_NONE, 0, 1'b1);
        plan_trip(1'b0, ACT_RUN_LOW, $urandom_range(1, SCAN_LEN - 1), 1'b0);
        plan_idle(3);
        run_queue();
    endtask

    task automatic test_oneshot();
        oneshot = 1'b1;
        plan_idle(1);
        run_queue();
        for (int k = 0; k < 2; k++) begin
            run = 1'b1;
            plan_trip(1'b1, ACT_NONE, 0, 1'b0);
            plan_idle($urandom_range(3, 6));
            run_queue();
            run = 1'b0;
            plan_idle(1);
            run_queue();
        end
        oneshot = 1'b0;
    endtask

    task automatic test_abort();
        for (int k = 0; k < 2; k++) begin
            int ap;
            ap = (k == 0) ? 8 : $urandom_range(1, SCAN_LEN - 1);
            run = 1'b1;
            plan_trip(1'b1, ACT_ABORT, ap, 1'b0);
            run_queue();
            vectors++;
            if ({busy0, busy1, dir0, dir1} !== 4'b0000) begin
                errors++;
                $display("FAIL abort_to_idle pos%0d: busy=%b%b dir=%b%b required 00 00", ap, busy0, busy1, dir0, dir1);
            end
            run = 1'b0;
            plan_idle(1);
            run_queue();
        end
    endtask

    task automatic test_reset_mid_sweep();
        run = 1'b1;
        plan_trip(1'b1, ACT_RESET, 12, 1'b1);
        run_queue();
        plan_trip(1'b1, ACT_RUN_LOW, $urandom_range(1, SCAN_LEN - 1), 1'b0);
        plan_idle(2);
        run_queue();
    endtask

    initial begin
        test_reset();
        test_ramp_round_trip();
        test_back_to_back();
        test_oneshot();
        test_abort();
        test_reset_mid_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/stepper_scan_ctrl.md
# stepper_scan_ctrl

Parametrised scan-head controller: drives a stepper through repeated home-to-far-end sweeps and generates the LED-bar pixel strobe/index for a window inside each sweep. It is the next generation of the fixed 128-position scanner, with configurable scan length, pixel window and acceleration ramp, plus unidirectional-imaging, one-shot and abort modes. It sits between the top-level control inputs and the motor driver/LED shift logic.

## Interface
- CLK_DIV, 20: clk cycles per motion tick, ≥2
- POS_W, 7: position counter width
- SCAN_LEN, 126: far-end position, home is 0; SCAN_LEN < 2^POS_W
- WIN_START, 15: first pixel position
- WIN_LEN, 100: pixel count; WIN_START+WIN_LEN ≤ SCAN_LEN
- RAMP_LEN, 14: ramp zone depth at each end; 2·RAMP_LEN ≤ SCAN_LEN
- RAMP_SHIFT, 2: ramp slope shift
- UNIDIR, 0: 1 = pixels only on forward sweep
- PIX_W = $clog2(WIN_LEN), derived
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- run  in  1  keep scanning while high
- oneshot  in  1  1 = one round trip per run assertion
- abort  in  1  force immediate return to home
- step  out  1  one-clk motor step pulse
- dir  out  1  0 = toward far end, 1 = toward home
- pixel_clock  out  1  one-clk pixel strobe, coincident with step
- nOE  out  1  LED output enable, active low
- pixel_idx  out  PIX_W  current pixel, 0..WIN_LEN-1
- pos  out  POS_W  current motor position
- busy  out  1  state ≠ IDLE
- line_done  out  1  one-clk pulse on each reversal dwell tick

## Operation
- Tick: divider counts 0..CLK_DIV-1 freely from reset; tick = count==CLK_DIV-1. All state, pos and wait updates happen only on tick cycles.
- States: IDLE, FWD, REV (shared enum).
- Step period: d = min(pos, SCAN_LEN-pos); P = 1+((RAMP_LEN-d)>>RAMP_SHIFT) if d<RAMP_LEN, else 1. wait counter counts ticks since the last step. On a tick in FWD/REV, if wait+1 ≥ P: step, pos±1, wait←0; else wait++.
- IDLE: on a tick with run=1 and armed=1 → FWD, wait←0. No step on the start tick.
- FWD: the step that sets pos=SCAN_LEN stays in FWD. The next tick is a dwell tick: →REV, no step, line_done pulse.
- REV: the step that sets pos=0 stays in REV. The next tick is a dwell tick with line_done. Then →FWD if run=1 && !oneshot && !abort_latched, else →IDLE.
- armed: set on reset and whenever run=0. Cleared on IDLE→FWD if oneshot=1.
- abort: sampled every clk into abort_latched. On the next tick in FWD, take a dwell tick →REV with no step. Ignored in IDLE/REV except it blocks restart. abort_latched clears on entry to IDLE.
- Pixel: a step that moves pos to p ∈ [WIN_START, WIN_START+WIN_LEN-1] pulses pixel_clock (FWD always; REV only if UNIDIR=0) and loads pixel_idx←p-WIN_START.
- nOE = 0 iff pos is in the window and (state==FWD or (state==REV && !UNIDIR)); registered.
- dir registered = (state==REV).

## Timing
- Reset values: step 0, dir 0, pixel_clock 0, nOE 1, pixel_idx 0, pos 0, busy 0, line_done 0, divider 0, wait 0, IDLE, armed 1.
- Latency: step, pixel_clock, line_done, pos and dir are all registered and assert/update on the clk edge ending the tick cycle. Each pulse is exactly 1 clk.
- dir changes only on dwell ticks, where step=0, so dir is always stable ≥CLK_DIV clk cycles before any step.
- Minimum step spacing is CLK_DIV clk cycles.
- Reset mid-sweep: all outputs return to reset values next edge. No step is emitted.
- run dropping mid-sweep: the current round trip completes, then IDLE.

## Structure
- stepper_scan_pkg: state enum, ramp-period function, parameter legality checks.
- One sub-module, clk_tick_gen(CLK_DIV), for the divider/tick.
- The rest is one FSM + datapath in stepper_scan_ctrl.

## Test plan
Bench parameters: CLK_DIV=4, SCAN_LEN=20, WIN_START=5, WIN_LEN=10, RAMP_LEN=4, RAMP_SHIFT=0.
- run=1 from IDLE → the start tick is followed by step intervals of 5,4,3,2 ticks at pos 0..3, then 1 tick. pos reaches 20. Dwell tick with line_done, dir→1.
- Full round trip, UNIDIR=0 → 10 pixel_clock pulses per sweep. pixel_idx goes 0..9 forward, 9..0 reverse. nOE=0 only while pos ∈ 5..14.
- UNIDIR=1 → 10 pixel_clock pulses on FWD, 0 on REV, nOE=1 throughout REV.
- oneshot=1, run held high → exactly one round trip, then IDLE. A run low→high pulse starts another.
- abort pulse at pos=8 in FWD → next tick is a dwell (no step), dir=1, return to 0, then IDLE despite run=1.
- reset asserted at pos=12 → next edge pos=0, nOE=1, step=0, busy=0. Restart occurs normally.
